// File: rtl/wide_word_uart_tx.sv
// Wide operand to 8N1 UART byte stream serialiser.
// Latency: tx falls one cycle after start is accepted; done rises NFRAMES*10 + (NFRAMES-1)*GAP_BITS bit-times later.
// Backpressure: none; start is only honoured in IDLE, and start or data changes while busy are ignored.
//
// Snapshots DATA_W bits on an accepted start, then sends NBYTES frames
// (start bit, 8 data bits LSB first, stop bit). Optional idle-high gap between frames.
// Byte order: MSB_FIRST=0 sends data[7:0] first; MSB_FIRST=1 sends the top byte first.
// Optional macro WIDE_TXD_CHECKSUM_EN appends one frame holding the XOR of all data bytes.
//
// Ports:
//   clock     system clock
//   reset     synchronous, active-high
//   start     transfer request, accepted only in IDLE
//   data      operand, captured on the accepting edge
//   busy      high while a transfer is in flight
//   done      level, set when the last frame completes, cleared by the next accepted start
//   tx        UART line, idles high
//   byte_idx  frames fully sent in the current transfer, saturating at NFRAMES
module wide_word_uart_tx #(
  parameter int DATA_W       = 512,
  parameter int CLKS_PER_BIT = 868,
  parameter bit MSB_FIRST    = 1'b0,
  parameter int GAP_BITS     = 0,
`ifdef WIDE_TXD_CHECKSUM_EN
  localparam int NFRAMES     = DATA_W / 8 + 1,
`else
  localparam int NFRAMES     = DATA_W / 8,
`endif
  localparam int BIDX_W      = $clog2(NFRAMES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              tx,
  output logic [BIDX_W-1:0] byte_idx
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX  = (GAP_CLKS > CLKS_PER_BIT) ? GAP_CLKS : CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [BIDX_W-1:0] LAST_FRAME = BIDX_W'(NFRAMES - 1);
  localparam logic [BIDX_W-1:0] ALL_FRAMES = BIDX_W'(NFRAMES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_clk_cnt;
  logic [2:0]         r_bit_cnt;
  logic [BIDX_W-1:0]  r_byte_idx;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;

  logic [7:0]         w_cur_byte;
  logic [7:0]         w_frame_byte;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               w_bit_end;
  logic               w_gap_end;
  logic               w_last_frame;
  logic               w_line;

  // The byte on air always sits at the outgoing end of the snapshot, so
  // selection is a fixed slice and the shift moves the next byte into place.
  assign w_cur_byte   = MSB_FIRST ? r_shift[DATA_W-1 -: 8] : r_shift[7:0];
  assign w_shift_nxt  = MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
  assign w_bit_end    = (r_clk_cnt == BIT_LAST);
  assign w_gap_end    = (r_clk_cnt == GAP_LAST);
  assign w_last_frame = (r_byte_idx == LAST_FRAME);

`ifdef WIDE_TXD_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       w_csum_frame;

  // Once all data bytes are out, byte_idx equals NBYTES and the trailing frame is the checksum.
  assign w_csum_frame = (r_byte_idx == BIDX_W'(NBYTES));
  assign w_frame_byte = w_csum_frame ? r_csum : w_cur_byte;

  // Each data byte is folded in as its frame completes, before the shifter advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_csum <= 8'h00;
    end else if (r_state == ST_IDLE && start) begin
      r_csum <= 8'h00;
    end else if (r_state == ST_STOP && w_bit_end && !w_csum_frame) begin
      r_csum <= r_csum ^ w_cur_byte;
    end
  end
`else
  assign w_frame_byte = w_cur_byte;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The line level is decoded from the current state and registered, so tx
  // lags the state by one cycle and is glitch-free at the pin.
  always_comb begin
    w_state_nxt = r_state;
    w_line      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_line = 1'b0;
        if (w_bit_end) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_line = w_frame_byte[r_bit_cnt];
        if (w_bit_end && r_bit_cnt == 3'd7) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (w_last_frame)      w_state_nxt = ST_DONE;
          else if (GAP_CLKS > 0) w_state_nxt = ST_GAP;
          else                   w_state_nxt = ST_START;
        end
      end
      ST_GAP: begin
        if (w_gap_end) w_state_nxt = ST_START;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shift    <= '0;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= 3'd0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx <= w_line;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift    <= data;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_byte_idx <= '0;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= 3'd0;
          end
        end
        ST_START: begin
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
        end
        ST_DATA: begin
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
          // Wraps 7 -> 0 so the next frame starts at bit 0.
          if (w_bit_end) r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        ST_STOP: begin
          r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + CNT_W'(1);
          if (w_bit_end) begin
            if (r_byte_idx != ALL_FRAMES) r_byte_idx <= r_byte_idx + BIDX_W'(1);
            r_shift <= w_shift_nxt;
          end
        end
        ST_GAP: begin
          r_clk_cnt <= w_gap_end ? '0 : r_clk_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign tx       = r_tx;
  assign byte_idx = r_byte_idx;

endmodule

// File: tb/tb_wide_word_uart_tx.sv
// Directed bench for wide_word_uart_tx: 16-bit operand, 4 clocks per bit.
// Three instances: LSB-first, MSB-first, and LSB-first with a 2-bit-time gap.
// Line timing is checked at exact clock edges, sampled on the falling edge.
module tb_wide_word_uart_tx;

  localparam int C = 4;
`ifdef WIDE_TXD_CHECKSUM_EN
  localparam int NFR = 3;
  localparam int T0  = 120;
  localparam int TG  = 136;
`else
  localparam int NFR = 2;
  localparam int T0  = 80;
  localparam int TG  = 88;
`endif

  logic        clock;
  logic        reset;
  logic [2:0]  st;
  logic [15:0] dat;

  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c;
  logic [1:0] idx_a, idx_b, idx_c;

  int   sel;
  logic m_tx, m_busy, m_done;
  logic [1:0] m_idx;

  int cyc;
  int chg_at;
  int n_chk;
  int n_fail;

  wide_word_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(C), .MSB_FIRST(1'b0), .GAP_BITS(0)) u_lsb (
    .clock(clock), .reset(reset), .start(st[0]), .data(dat),
    .busy(busy_a), .done(done_a), .tx(tx_a), .byte_idx(idx_a)
  );

  wide_word_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(C), .MSB_FIRST(1'b1), .GAP_BITS(0)) u_msb (
    .clock(clock), .reset(reset), .start(st[1]), .data(dat),
    .busy(busy_b), .done(done_b), .tx(tx_b), .byte_idx(idx_b)
  );

  wide_word_uart_tx #(.DATA_W(16), .CLKS_PER_BIT(C), .MSB_FIRST(1'b0), .GAP_BITS(2)) u_gap (
    .clock(clock), .reset(reset), .start(st[2]), .data(dat),
    .busy(busy_c), .done(done_c), .tx(tx_c), .byte_idx(idx_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  always_comb begin
    case (sel)
      1:       begin m_tx = tx_b; m_busy = busy_b; m_done = done_b; m_idx = idx_b; end
      2:       begin m_tx = tx_c; m_busy = busy_c; m_done = done_c; m_idx = idx_c; end
      default: begin m_tx = tx_a; m_busy = busy_a; m_done = done_a; m_idx = idx_a; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  // Advance falling edges until the edge counter reaches tgt; also applies
  // the scheduled operand change used by the snapshot test.
  task automatic wait_edge(input int tgt);
    while (cyc < tgt) begin
      @(negedge clock);
      if (chg_at != 0 && cyc == chg_at) dat = 16'h0000;
    end
  endtask

  // One transfer on instance 'sel'. exp holds frame bytes, frame 0 in [7:0].
  task automatic run(input logic [23:0] exp, input int gap, input int tt,
                     input bit hold, input bit chg);
    int n;
    int f;
    logic [7:0] b;
    st[sel] = 1'b1;
    @(negedge clock);
    n = cyc;
    chg_at = chg ? n + 2 : 0;
    if (!hold) st[sel] = 1'b0;
    check("acc_busy", m_busy, 1);
    check("acc_done", m_done, 0);
    check("acc_tx_idle", m_tx, 1);
    for (int k = 0; k < NFR; k++) begin
      f = n + 1 + k * (10 + gap) * C;
      if (k > 0) begin
        for (int e = f - gap * C; e < f; e++) begin
          wait_edge(e);
          check("gap_idle", m_tx, 1);
        end
      end
      wait_edge(f - 1);
      check("pre_start", m_tx, 1);
      wait_edge(f);
      check("start_bit", m_tx, 0);
      check("byte_idx", m_idx, k);
      for (int i = 0; i < 8; i++) begin
        wait_edge(f + C * (i + 1) + 1);
        b[i] = m_tx;
      end
      check("byte", b, exp[8*k +: 8]);
      wait_edge(f + 9 * C + 1);
      check("stop_bit", m_tx, 1);
    end
    wait_edge(n + tt);
    check("done_early", m_done, 0);
    check("busy_end", m_busy, 1);
    wait_edge(n + tt + 1);
    check("done_rise", m_done, 1);
    check("busy_fall", m_busy, 0);
    check("idx_final", m_idx, NFR);
    chg_at = 0;
  endtask

  initial begin
    int n;
    n_chk  = 0;
    n_fail = 0;
    chg_at = 0;
    sel    = 0;
    reset  = 1'b1;
    st     = 3'b000;
    dat    = 16'hA55A;
    repeat (3) @(negedge clock);
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_idx_a", idx_a, 0);
    check("rst_tx_b", tx_b, 1);
    check("rst_busy_b", busy_b, 0);
    check("rst_tx_c", tx_c, 1);
    check("rst_idx_c", idx_c, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Basic LSB-first transfer
    sel = 0;
    @(negedge clock);
    run({8'hFF, 8'hA5, 8'h5A}, 0, T0, 1'b0, 1'b0);

    // MSB-first order
    sel = 1;
    @(negedge clock);
    run({8'hFF, 8'h5A, 8'hA5}, 0, T0, 1'b0, 1'b0);

    // Gap between frames, operand cleared two cycles after start
    sel = 2;
    @(negedge clock);
    run({8'hFF, 8'hA5, 8'h5A}, 2, TG, 1'b0, 1'b1);
    check("data_cleared", dat, 16'h0000);
    dat = 16'hA55A;

    // start held through a transfer, then an immediate restart
    sel = 0;
    @(negedge clock);
    run({8'hFF, 8'hA5, 8'h5A}, 0, T0, 1'b1, 1'b0);
    run({8'hFF, 8'hA5, 8'h5A}, 0, T0, 1'b0, 1'b0);

    // Reset during bit 3 of byte 0 (0xA5, bit 3 = 0), then a clean transfer
    sel = 0;
    dat = 16'hA5A5;
    @(negedge clock);
    st[0] = 1'b1;
    @(negedge clock);
    n = cyc;
    st[0] = 1'b0;
    wait_edge(n + 18);
    check("mid_bit3", tx_a, 0);
    reset = 1'b1;
    wait_edge(n + 19);
    check("abort_tx", tx_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_idx", idx_a, 0);
    reset = 1'b0;
    dat = 16'hA55A;
    wait_edge(n + 22);
    check("post_rst_idle", tx_a, 1);
    run({8'hFF, 8'hA5, 8'h5A}, 0, T0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
